// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write-back path.
// The write stage, the ALU result buffer and the top-level arbiter all
// pass results around as wb_req_t {rd, data}.
package regfile_pkg;

  localparam int REG_COUNT  = 32;
  localparam int ADDR_WIDTH = $clog2(REG_COUNT);
  localparam int DATA_WIDTH = 32;

  // One write-back request: destination register and the value to write.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of write-back requests used to buffer ALU results
// while the LSU owns the register-file write port.
// push is ignored when full and pop is ignored when empty, so callers may
// drive them from plain valid signals. DEPTH must be a power of two >= 2 so
// the pointers wrap naturally.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  wb_req_t din,
  input  logic    pop,
  output wb_req_t dout,
  output logic    full,
  output logic    empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_req_t       mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; a push and pop together keep count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-side initiator for the 2R/1W register file.
// Merges LSU and ALU results onto the single registered write port and keeps
// a per-register pending-write scoreboard for decode RAW hazard detection.
//
// Arbitration: LSU wins by default; ALU results wait in a small FIFO. If the
// FIFO head has waited STARVE_LIMIT cycles, the LSU is stalled for one cycle
// (lsu_ready_o=0) and the head is forced through.
//
// Handshakes: a result is transferred on a clock edge where valid and ready
// are both high; ready never depends on the same-cycle valid of that source.
//
// Optional feature: define WB_ALU_BYPASS_EN to let an ALU result skip the
// FIFO when the FIFO is empty and the LSU is idle (1-cycle ALU latency).
// Without it every ALU result takes at least 2 cycles via the FIFO.
module regfile_wb_arbiter #(
  parameter int REG_COUNT      = regfile_pkg::REG_COUNT,
  parameter int ADDR_WIDTH     = $clog2(REG_COUNT),
  parameter int DATA_WIDTH     = regfile_pkg::DATA_WIDTH,
  parameter int ALU_FIFO_DEPTH = 2,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  iss_valid_i,
  input  logic [ADDR_WIDTH-1:0] iss_rd_i,
  input  logic                  alu_valid_i,
  input  logic [ADDR_WIDTH-1:0] alu_rd_i,
  input  logic [DATA_WIDTH-1:0] alu_data_i,
  output logic                  alu_ready_o,
  input  logic                  lsu_valid_i,
  input  logic [ADDR_WIDTH-1:0] lsu_rd_i,
  input  logic [DATA_WIDTH-1:0] lsu_data_i,
  output logic                  lsu_ready_o,
  output logic [ADDR_WIDTH-1:0] waddr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic                  we_o,
  input  logic [ADDR_WIDTH-1:0] raddr_a_i,
  input  logic [ADDR_WIDTH-1:0] raddr_b_i,
  output logic                  hazard_a_o,
  output logic                  hazard_b_o
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  regfile_pkg::wb_req_t alu_req;
  regfile_pkg::wb_req_t lsu_req;
  regfile_pkg::wb_req_t fifo_head;
  regfile_pkg::wb_req_t slot_req;

  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 starve_force;
  logic                 lsu_take;
  logic                 alu_take;
  logic                 bypass;
  logic                 slot_valid;
  logic [SW-1:0]        starve_cnt;
  logic [REG_COUNT-1:0] pending;
  logic [REG_COUNT-1:0] pending_nxt;

  assign alu_req = '{rd: alu_rd_i, data: alu_data_i};
  assign lsu_req = '{rd: lsu_rd_i, data: lsu_data_i};

  // ---------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------
  assign starve_force = !fifo_empty && (starve_cnt == SW'(STARVE_LIMIT));
  assign lsu_ready_o  = !starve_force;
  assign alu_ready_o  = !fifo_full;
  assign lsu_take     = lsu_valid_i && lsu_ready_o;
  assign alu_take     = alu_valid_i && alu_ready_o;

  // The head leaves either because the LSU is idle or because it is starving.
  // When starving, lsu_ready_o is low, so lsu_take and fifo_pop never overlap.
  assign fifo_pop = !fifo_empty && (starve_force || !lsu_valid_i);

`ifdef WB_ALU_BYPASS_EN
  assign bypass = alu_take && fifo_empty && !lsu_valid_i && !starve_force;
`else
  assign bypass = 1'b0;
`endif

  assign fifo_push = alu_take && !bypass;

  // Pick the request that owns the write stage on the coming edge.
  always_comb begin
    slot_valid = 1'b0;
    slot_req   = lsu_req;
    if (lsu_take) begin
      slot_valid = 1'b1;
      slot_req   = lsu_req;
    end else if (fifo_pop) begin
      slot_valid = 1'b1;
      slot_req   = fifo_head;
    end else if (bypass) begin
      slot_valid = 1'b1;
      slot_req   = alu_req;
    end
  end

  // Age of the FIFO head: counts blocked cycles, saturates, clears on a pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (fifo_pop || fifo_empty) begin
      starve_cnt <= '0;
    end else if (starve_cnt != SW'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  wb_fifo #(
    .DEPTH (ALU_FIFO_DEPTH)
  ) u_alu_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (alu_req),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ---------------------------------------------------------------------
  // Write stage
  // ---------------------------------------------------------------------
  // Registered write port; a slot to x0 is consumed but never asserts we_o.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_o    <= 1'b0;
      waddr_o <= '0;
      wdata_o <= '0;
    end else begin
      we_o <= slot_valid && (slot_req.rd != '0);
      if (slot_valid) begin
        waddr_o <= slot_req.rd;
        wdata_o <= slot_req.data;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Pending-write scoreboard
  // ---------------------------------------------------------------------
  // Commit clears first so that an issue to the same register wins.
  always_comb begin
    pending_nxt = pending;
    if (we_o) begin
      pending_nxt[waddr_o] = 1'b0;
    end
    if (iss_valid_i && (iss_rd_i != '0)) begin
      pending_nxt[iss_rd_i] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
  end

  // Scoreboard state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  assign hazard_a_o = (raddr_a_i != '0) && pending[raddr_a_i];
  assign hazard_b_o = (raddr_b_i != '0) && pending[raddr_b_i];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// queue-based reference model of the write-back rules.
module tb_regfile_wb_arbiter;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int RW    = AW + DW;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          iss_valid;
  logic [AW-1:0] iss_rd;
  logic          alu_valid;
  logic [AW-1:0] alu_rd;
  logic [DW-1:0] alu_data;
  logic          alu_ready_o;
  logic          lsu_valid;
  logic [AW-1:0] lsu_rd;
  logic [DW-1:0] lsu_data;
  logic          lsu_ready_o;
  logic [AW-1:0] waddr_o;
  logic [DW-1:0] wdata_o;
  logic          we_o;
  logic [AW-1:0] raddr_a;
  logic [AW-1:0] raddr_b;
  logic          hazard_a_o;
  logic          hazard_b_o;

  regfile_wb_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .iss_valid_i (iss_valid),
    .iss_rd_i    (iss_rd),
    .alu_valid_i (alu_valid),
    .alu_rd_i    (alu_rd),
    .alu_data_i  (alu_data),
    .alu_ready_o (alu_ready_o),
    .lsu_valid_i (lsu_valid),
    .lsu_rd_i    (lsu_rd),
    .lsu_data_i  (lsu_data),
    .lsu_ready_o (lsu_ready_o),
    .waddr_o     (waddr_o),
    .wdata_o     (wdata_o),
    .we_o        (we_o),
    .raddr_a_i   (raddr_a),
    .raddr_b_i   (raddr_b),
    .hazard_a_o  (hazard_a_o),
    .hazard_b_o  (hazard_b_o)
  );

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int passes = 0;

  // Buffered ALU results awaiting their write slot, oldest first.
  logic [RW-1:0] exp_q[$];
  int            m_wait;   // cycles the oldest buffered ALU result has been blocked
  logic [31:0]   m_pend;   // registers with an outstanding write
  logic          m_we;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_wait  = 0;
    m_pend  = '0;
    m_we    = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
  endtask

  // Apply one clock edge's worth of rules to the model using current inputs.
  task automatic model_edge();
    logic          starving;
    logic          lsu_acc;
    logic          alu_acc;
    logic          have;
    logic          popped;
    logic [RW-1:0] w;
    if (!rst_n) begin
      model_reset();
      return;
    end
    starving = (exp_q.size() != 0) && (m_wait >= LIMIT);
    lsu_acc  = lsu_valid && !starving;
    alu_acc  = alu_valid && (exp_q.size() < DEPTH);
    have     = 1'b0;
    popped   = 1'b0;
    w        = '0;
    if (m_we) m_pend[m_waddr] = 1'b0;
    if (iss_valid && iss_rd != 0) m_pend[iss_rd] = 1'b1;
    if (lsu_acc) begin
      have = 1'b1;
      w    = {lsu_rd, lsu_data};
    end else if (exp_q.size() != 0) begin
      have   = 1'b1;
      w      = exp_q.pop_front();
      popped = 1'b1;
    end
`ifdef WB_ALU_BYPASS_EN
    else if (alu_acc) begin
      have    = 1'b1;
      w       = {alu_rd, alu_data};
      alu_acc = 1'b0;
    end
`endif
    if (popped || exp_q.size() == 0) m_wait = 0;
    else if (m_wait < LIMIT) m_wait = m_wait + 1;
    if (alu_acc) exp_q.push_back({alu_rd, alu_data});
    m_we = have && (w[RW-1 -: AW] != 0);
    if (have) begin
      m_waddr = w[RW-1 -: AW];
      m_wdata = w[DW-1:0];
    end
  endtask

  task automatic check_regs();
    chk("we", 32'(we_o), 32'(m_we));
    if (m_we) begin
      chk("waddr", 32'(waddr_o), 32'(m_waddr));
      chk("wdata", wdata_o, m_wdata);
    end
  endtask

  task automatic check_comb();
    chk("alu_ready", 32'(alu_ready_o), 32'(exp_q.size() < DEPTH));
    chk("lsu_ready", 32'(lsu_ready_o), 32'(!((exp_q.size() != 0) && (m_wait >= LIMIT))));
    chk("hazard_a", 32'(hazard_a_o), 32'((raddr_a != 0) && m_pend[raddr_a]));
    chk("hazard_b", 32'(hazard_b_o), 32'((raddr_b != 0) && m_pend[raddr_b]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    iss_valid = 1'b0;
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
  endtask

  // Inputs are set by the caller just after an edge; comb outputs are checked
  // before the next edge, registered outputs just after it.
  task automatic run_cycle();
    #1;
    check_comb();
    @(posedge clk);
    model_edge();
    #1;
    check_regs();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int lsu_bias;
    iss_rd = '0; alu_rd = '0; alu_data = '0; lsu_rd = '0; lsu_data = '0;
    raddr_a = '0; raddr_b = '0;
    idle();

    // Reset held with an ALU result offered.
    rst_n = 1'b0; alu_valid = 1'b1; alu_rd = 5'd4; raddr_a = 5'd4;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    run_cycle();
    run_cycle();
    chk("rst_we", 32'(we_o), 32'd0);
    chk("rst_hazard_a", 32'(hazard_a_o), 32'd0);
    rst_n = 1'b1; alu_valid = 1'b0;
    #1 chk("rst_alu_ready", 32'(alu_ready_o), 32'd1);

    // Issue rd=5, then LSU write to rd=5.
    idle(); iss_valid = 1'b1; iss_rd = 5'd5; run_cycle();
    idle(); lsu_valid = 1'b1; lsu_rd = 5'd5; lsu_data = 32'hDEADBEEF; raddr_a = 5'd5;
    #1 chk("haz_before_commit", 32'(hazard_a_o), 32'd1);
    run_cycle();
    chk("lsu_we", 32'(we_o), 32'd1);
    chk("lsu_waddr", 32'(waddr_o), 32'd5);
    chk("lsu_wdata", wdata_o, 32'hDEADBEEF);
    idle(); run_cycle();
    #1 chk("haz_after_commit", 32'(hazard_a_o), 32'd0);

    // ALU and LSU in the same cycle: LSU first, ALU next.
    idle(); alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h77;
    run_cycle();
    chk("order_first", 32'(waddr_o), 32'd7);
    idle(); run_cycle();
    chk("order_second_we", 32'(we_o), 32'd1);
    chk("order_second", 32'(waddr_o), 32'd3);

    // Starvation: LSU busy, one buffered ALU result forced out after 4 waits.
    idle(); lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_data = 32'hA0;
    alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'hC0;
    run_cycle();
    alu_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 chk("starve_wait_ready", 32'(lsu_ready_o), 32'd1);
      run_cycle();
      chk("starve_lsu_slot", 32'(waddr_o), 32'd10);
    end
    #1 chk("starve_force_ready", 32'(lsu_ready_o), 32'd0);
    run_cycle();
    chk("starve_alu_out", 32'(waddr_o), 32'd12);
    chk("starve_alu_data", wdata_o, 32'hC0);
    #1 chk("starve_release", 32'(lsu_ready_o), 32'd1);

    // FIFO fill with LSU busy: third ALU result sees ready low.
    alu_valid = 1'b1; alu_rd = 5'd13; alu_data = 32'hD0; run_cycle();
    alu_rd = 5'd14; alu_data = 32'hE0; run_cycle();
    alu_rd = 5'd15; alu_data = 32'hF0;
    #1 chk("full_alu_ready", 32'(alu_ready_o), 32'd0);
    run_cycle();
    idle(); repeat (4) run_cycle();

    // rd=0 results consume a slot without a write.
    idle(); lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h1234; run_cycle();
    chk("x0_lsu_we", 32'(we_o), 32'd0);
    idle(); alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234; run_cycle();
    chk("x0_alu_we_a", 32'(we_o), 32'd0);
    idle(); run_cycle();
    chk("x0_alu_we_b", 32'(we_o), 32'd0);
    idle(); iss_valid = 1'b1; iss_rd = 5'd0; run_cycle();
    idle(); raddr_a = 5'd0; raddr_b = 5'd0;
    #1 chk("x0_no_hazard", 32'(hazard_a_o), 32'd0);

    // Issue and commit of rd=9 on the same edge: pending stays set.
    idle(); iss_valid = 1'b1; iss_rd = 5'd9; run_cycle();
    idle(); lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h99; run_cycle();
    chk("set_clr_we", 32'(we_o), 32'd1);
    idle(); iss_valid = 1'b1; iss_rd = 5'd9; run_cycle();
    idle(); raddr_b = 5'd9;
    #1 chk("set_wins", 32'(hazard_b_o), 32'd1);
    lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h98; run_cycle();
    idle(); run_cycle();
    #1 chk("set_wins_cleared", 32'(hazard_b_o), 32'd0);

    // ALU latency from an idle state.
    idle(); repeat (2) run_cycle();
    alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h66; run_cycle();
    idle();
`ifdef WB_ALU_BYPASS_EN
    chk("alu_lat1_we", 32'(we_o), 32'd1);
    chk("alu_lat1_addr", 32'(waddr_o), 32'd6);
`else
    chk("alu_lat2_early", 32'(we_o), 32'd0);
    run_cycle();
    chk("alu_lat2_we", 32'(we_o), 32'd1);
    chk("alu_lat2_addr", 32'(waddr_o), 32'd6);
`endif

    // Randomized traffic in three LSU-load phases with a mid-run reset.
    for (int c = 0; c < 3000; c++) begin
      lsu_bias  = (c < 1000) ? 3 : (c < 2000) ? 9 : 1;
      rst_n     = !(c == 2500);
      iss_valid = ($urandom_range(0, 2) == 0);
      iss_rd    = AW'($urandom_range(0, 7));
      alu_valid = ($urandom_range(0, 1) == 1);
      alu_rd    = AW'($urandom_range(0, 7));
      alu_data  = $urandom;
      lsu_valid = ($urandom_range(0, 9) < lsu_bias);
      lsu_rd    = AW'($urandom_range(0, 7));
      lsu_data  = $urandom;
      raddr_a   = AW'($urandom_range(0, 7));
      raddr_b   = AW'($urandom_range(0, 7));
      run_cycle();
    end
    rst_n = 1'b1;
    idle();
    repeat (8) run_cycle();

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Write-side initiator for the core's 2R/1W register file. Merges ALU and LSU results onto the single write port (waddr/wdata/we).
- Keeps a per-register pending-write scoreboard so decode can detect RAW hazards on its two read addresses.
- Sits between the execute/memory stages and the register file's write port.

Parameters:
REG_COUNT, 32, number of architectural registers; x0 is hardwired zero.
ADDR_WIDTH, $clog2(REG_COUNT), register address width.
DATA_WIDTH, 32, register data width.
ALU_FIFO_DEPTH, 2, ALU result buffer entries; power of two, ≥2.
STARVE_LIMIT, 4, cycles an ALU FIFO head may wait before it is forced through.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
iss_valid_i  in  1  instruction with destination issued this cycle
iss_rd_i  in  ADDR_WIDTH  destination register of the issued instruction
alu_valid_i  in  1  ALU result valid
alu_rd_i  in  ADDR_WIDTH  ALU destination
alu_data_i  in  DATA_WIDTH  ALU result
alu_ready_o  out  1  ALU result accepted when valid&ready
lsu_valid_i  in  1  load result valid
lsu_rd_i  in  ADDR_WIDTH  load destination
lsu_data_i  in  DATA_WIDTH  load data
lsu_ready_o  out  1  load result accepted when valid&ready
waddr_o  out  ADDR_WIDTH  register file write address
wdata_o  out  DATA_WIDTH  register file write data
we_o  out  1  register file write enable
raddr_a_i  in  ADDR_WIDTH  decode read address A
raddr_b_i  in  ADDR_WIDTH  decode read address B
hazard_a_o  out  1  pending write to raddr_a_i
hazard_b_o  out  1  pending write to raddr_b_i

Behaviour:
- Reset (clk edge with rst_n=0):
  - we_o=0, waddr_o=0, wdata_o=0.
  - All pending bits cleared; FIFO empty (pointers 0, count 0); starve counter 0.
  - Reset mid-operation discards buffered ALU results without writing them.
- Write stage: waddr_o/wdata_o/we_o are registered and held one cycle per commit. The register file commits on the edge where we_o=1.
- Arbitration, once per cycle:
  - Normal case: LSU has priority. lsu_ready_o=1. A valid LSU result is latched into the write stage.
  - The ALU FIFO head pops only when LSU is not valid.
  - Starvation override: if starve counter == STARVE_LIMIT and FIFO is non-empty, lsu_ready_o=0 and the FIFO head pops.
  - Starve counter increments each cycle the FIFO is non-empty without a pop, saturates at STARVE_LIMIT, and clears on any pop.
- ALU FIFO:
  - alu_ready_o = !full. A push on valid&ready goes to the tail.
  - Simultaneous push and pop when full is not allowed (ready=0). Push and pop together at any other count leaves the count unchanged.
  - Pointers wrap modulo ALU_FIFO_DEPTH.
- Latency, valid&ready edge to we_o=1:
  - LSU: 1 cycle.
  - ALU via FIFO: 2 cycles minimum.
- rd=0: the result is consumed normally, but we_o stays 0 for that slot. x0 is never marked pending.
- Scoreboard:
  - iss_valid_i with iss_rd_i≠0 sets pending[rd].
  - The edge that commits a write (we_o=1) clears pending[waddr_o].
  - Set and clear of the same register on the same edge: set wins.
- Hazards: hazard_x_o = pending[raddr_x_i] is combinational. It is always 0 for address 0. On the cycle after commit the hazard is 0 and the register file returns new data.
- No write is ever lost: every accepted result produces exactly one write slot, in acceptance order per source.

Optional Feature:
- Macro WB_ALU_BYPASS_EN.
- Defined: when the FIFO is empty, LSU is not valid, and the starve override is inactive, an accepted ALU result goes straight into the write stage. ALU latency becomes 1 cycle and the FIFO is untouched.
- Undefined: every ALU result goes through the FIFO, so ALU latency is at least 2 cycles.

Decomposition:
- Package regfile_pkg holds:
  - REG_COUNT, ADDR_WIDTH, DATA_WIDTH constants.
  - typedef wb_req_t {rd, data}.
- One sub-module, wb_fifo: parameterised sync FIFO of wb_req_t with push/pop/full/empty.

Test Plan:
- Reset: hold rst_n=0 with alu_valid_i=1 → we_o=0, hazards 0, alu_ready_o=1 after release.
- Issue rd=5, then LSU rd=5 data 0xDEADBEEF → next cycle we_o=1, waddr_o=5, wdata_o=0xDEADBEEF. hazard_a_o for raddr_a_i=5 is 1 before commit and 0 the cycle after.
- ALU rd=3 and LSU rd=7 valid in the same cycle → write rd=7 first, then rd=3 one cycle later.
- LSU valid continuously, one ALU result buffered → ALU forced out after exactly 4 waiting cycles with lsu_ready_o=0 for that cycle. Push 3 ALU results with LSU busy → third sees alu_ready_o=0.
- Any source with rd=0, data 0x1234 → no we_o pulse. Issue to rd=0 → hazard stays 0.
- Issue rd=9 on the same edge as commit of rd=9 → pending[9] remains 1. With WB_ALU_BYPASS_EN, an idle ALU result reaches we_o in 1 cycle; without it, 2 cycles.
